// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: EX/MEM bundle in, registered MEM/WB bundle out, data memory over req/ack.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_res,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_write_addr,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_pc_to_reg,
    input  logic [31:0]       ex_pc_plus4,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_write_addr,
    output logic              wb_reg_write,
    output logic              mem_misaligned,
    output logic              mem_timeout
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        dest_q, dest_d;
    logic              lat_rw_q, lat_rw_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic              wb_rw_q, wb_rw_d;
    logic              mis_q, mis_d;
    logic              to_q, to_d;

    logic mem_op, aligned, accept, abort;

    assign mem_op  = ex_mem_read | ex_mem_write;
    assign aligned = (ex_alu_res[1:0] == 2'b00);
    assign accept  = (state_q == IDLE) && ex_valid && mem_op && aligned;

`ifdef MEM_TIMEOUT_EN
    // cnt_q holds the number of ACCESS cycles already spent without an ack
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;

    assign abort = (state_q == ACCESS) && !dmem_ack && (cnt_q >= TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if (state_q == ACCESS && !dmem_ack && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (dmem_ack || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_out = (state_q == ACCESS);
    end

    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        lat_rw_d   = lat_rw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_rw_d    = 1'b0;
        mis_d      = 1'b0;
        to_d       = 1'b0;
        if (state_q == IDLE) begin
            if (ex_valid && !mem_op) begin
                wb_valid_d = 1'b1;
                wb_data_d  = ex_pc_to_reg ? ex_pc_plus4 : ex_alu_res;
                wb_addr_d  = ex_write_addr;
                wb_rw_d    = ex_reg_write && (ex_write_addr != 5'd0);
            end else if (ex_valid && !aligned) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = ex_write_addr;
                mis_d      = 1'b1;
            end else if (accept) begin
                // a store that also claims a read is a store; it never writes back
                req_d    = 1'b1;
                we_d     = ex_mem_write;
                addr_d   = ex_alu_res[ADDR_W-1:0];
                wdata_d  = ex_store_data;
                dest_d   = ex_write_addr;
                lat_rw_d = ex_reg_write & ~ex_mem_write;
            end
        end else if (dmem_ack) begin
            req_d      = 1'b0;
            wb_valid_d = 1'b1;
            wb_addr_d  = dest_q;
            if (!we_q) begin
                wb_data_d = dmem_rdata;
                wb_rw_d   = lat_rw_q && (dest_q != 5'd0);
            end
        end else if (abort) begin
            req_d      = 1'b0;
            wb_valid_d = 1'b1;
            to_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
            lat_rw_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            lat_rw_q   <= lat_rw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign wb_write_addr  = wb_addr_q;
    assign wb_reg_write   = wb_rw_q;
    assign mem_misaligned = mis_q;
    assign mem_timeout    = to_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a per-cycle expectation timeline built from instruction-level rules,
// compared every negedge, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int ADDR_W = 8;
    localparam int TCYC   = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int TO_LIM = TCYC;
`else
    localparam int TO_LIM = 1000000;
`endif
    localparam int TL_N = 8192;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ex_valid = 1'b0;
    logic [31:0]       ex_alu_res = '0;
    logic [31:0]       ex_store_data = '0;
    logic [4:0]        ex_write_addr = '0;
    logic              ex_mem_read = 1'b0;
    logic              ex_mem_write = 1'b0;
    logic              ex_reg_write = 1'b0;
    logic              ex_pc_to_reg = 1'b0;
    logic [31:0]       ex_pc_plus4 = '0;
    logic              stall_out;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata = '0;
    logic              dmem_ack = 1'b0;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [4:0]        wb_write_addr;
    logic              wb_reg_write;
    logic              mem_misaligned;
    logic              mem_timeout;

    mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TCYC)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .ex_write_addr(ex_write_addr),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_pc_to_reg(ex_pc_to_reg),
        .ex_pc_plus4(ex_pc_plus4), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .mem_misaligned(mem_misaligned), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Expected output picture for one clock cycle (the interval after a posedge)
    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        wbv;
        logic        wbr;
        logic        wba_chk;
        logic        wbd_chk;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t tl [TL_N];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    logic        snap_we;
    logic [7:0]  snap_addr;
    logic [31:0] snap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        req_cnt   <= req_cnt + int'(dmem_req);
        stall_cnt <= stall_cnt + int'(stall_out);
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en && cyc < TL_N) begin
            e = tl[cyc];
            chk("stall_out", {31'd0, stall_out}, {31'd0, e.stall});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, e.req});
            if (e.req) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
                chk("dmem_addr", {24'd0, dmem_addr}, {24'd0, e.addr});
                chk("dmem_wdata", dmem_wdata, e.wdata);
            end
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
            if (e.wbv) begin
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.wbr});
                if (e.wba_chk) chk("wb_write_addr", {27'd0, wb_write_addr}, {27'd0, e.wba});
                if (e.wbd_chk) chk("wb_data", wb_data, e.wbd);
            end
            chk("mem_misaligned", {31'd0, mem_misaligned}, {31'd0, e.mis});
            chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
        end
    end

    task automatic clear_tl();
        for (int i = 0; i < TL_N; i++) tl[i] = '0;
    endtask

    task automatic garbage();
        ex_valid      = 1'($urandom);
        ex_alu_res    = $urandom;
        ex_store_data = $urandom;
        ex_write_addr = 5'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        ex_reg_write  = 1'($urandom);
        ex_pc_to_reg  = 1'($urandom);
        ex_pc_plus4   = $urandom;
    endtask

    // Called at a negedge; the instruction is taken at the next posedge.
    // k = cycles until the ack is sampled (k > TO_LIM means it never comes).
    task automatic issue(input logic rd, input logic wr, input logic rw, input logic p2r,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] p4,
                         input logic [4:0] wa, input int k, input logic [31:0] rdata);
        int   n;
        int   lim;
        exp_t e;
        exp_t s;
        n = cyc + 1;
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
        ex_pc_to_reg = p2r; ex_alu_res = alu; ex_store_data = sd; ex_pc_plus4 = p4;
        ex_write_addr = wa; dmem_ack = 1'b0;
        e = '0;
        if (!(rd | wr)) begin
            e.wbv = 1'b1; e.wbd = p2r ? p4 : alu; e.wbd_chk = 1'b1;
            e.wba = wa; e.wba_chk = 1'b1; e.wbr = rw && (wa != 5'd0);
            tl[n] = e;
            @(negedge clk);
        end else if (alu[1:0] != 2'b00) begin
            e.wbv = 1'b1; e.mis = 1'b1;
            tl[n] = e;
            @(negedge clk);
        end else begin
            lim = (k <= TO_LIM) ? k : TO_LIM;
            for (int c = 0; c < lim; c++) begin
                s = '0; s.stall = 1'b1; s.req = 1'b1; s.we = wr;
                s.addr = alu[7:0]; s.wdata = sd;
                tl[n + c] = s;
            end
            e.wbv = 1'b1;
            if (k <= TO_LIM) begin
                e.wba = wa; e.wba_chk = 1'b1;
                e.wbr = !wr && rw && (wa != 5'd0);
                if (!wr) begin e.wbd = rdata; e.wbd_chk = 1'b1; end
            end else begin
                e.to = 1'b1;
            end
            tl[n + lim] = e;
            @(negedge clk);
            snap_we = dmem_we; snap_addr = dmem_addr; snap_wdata = dmem_wdata;
            garbage();
            while (cyc < n + lim - 1) @(negedge clk);
            if (k <= TO_LIM) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            garbage();
            ex_valid   = 1'b0;
            dmem_ack   = 1'($urandom);
            dmem_rdata = $urandom;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic random_instr();
        int          op;
        int          k;
        logic [31:0] alu;
        logic        rd, wr;
        op  = $urandom_range(0, 5);
        alu = $urandom;
        rd  = 1'b0; wr = 1'b0;
        case (op)
            2: rd = 1'b1;
            3: wr = 1'b1;
            4: begin rd = 1'b1; wr = 1'b1; end
            5: rd = 1'($urandom);
            default: ;
        endcase
        if (op == 5) begin
            wr = ~rd | 1'($urandom);
            if (alu[1:0] == 2'b00) alu[0] = 1'b1;
        end else if (op >= 2) begin
            alu[1:0] = 2'b00;
        end
`ifdef MEM_TIMEOUT_EN
        k = ($urandom_range(0, 4) == 0) ? 100 : $urandom_range(1, TCYC + 2);
`else
        k = $urandom_range(1, 6);
`endif
        issue(rd, wr, 1'($urandom), (op == 1), alu, $urandom, $urandom,
              5'($urandom_range(0, 31)), k, $urandom);
    endtask

    initial begin
        int r0, s0;
        clear_tl();
        chk_en = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);
        chk("reset dmem_addr", {24'd0, dmem_addr}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset stall_out", {31'd0, stall_out}, 32'd0);

        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 1, 32'h0);
        chk("alu wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu wb_data", wb_data, 32'h1234);
        chk("alu wb_write_addr", {27'd0, wb_write_addr}, 32'd5);
        chk("alu wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
        chk("alu no dmem_req", {31'd0, dmem_req}, 32'd0);

        r0 = req_cnt; s0 = stall_cnt;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        chk("load req cycles", req_cnt - r0, 32'd3);
        chk("load stall cycles", stall_cnt - s0, 32'd3);
        chk("load wb_data", wb_data, 32'hDEADBEEF);
        chk("load wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 32'h0, 5'd3, 1, 32'h0);
        chk("follow-on wb_data", wb_data, 32'h55);

        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5A5A5, 32'h0, 5'd4, 1, 32'h0);
        chk("store dmem_we", {31'd0, snap_we}, 32'd1);
        chk("store dmem_wdata", snap_wdata, 32'hA5A5A5A5);
        chk("store dmem_addr", {24'd0, snap_addr}, 32'h20);
        chk("store wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("store wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

        issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h777, 32'h0, 32'h44, 5'd31, 1, 32'h0);
        chk("jal wb_data", wb_data, 32'h44);
        chk("jal wb_write_addr", {27'd0, wb_write_addr}, 32'd31);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 32'h0, 32'h0, 5'd0, 1, 32'h0);
        chk("dest0 wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 5'd8, 1, 32'h0);
        chk("misaligned pulse", {31'd0, mem_misaligned}, 32'd1);
        chk("misaligned wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("misaligned wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("misaligned no dmem_req", {31'd0, dmem_req}, 32'd0);
        idle(1);
        chk("misaligned pulse ends", {31'd0, mem_misaligned}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        r0 = req_cnt;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 5'd9, 100, 32'h0);
        chk("timeout req cycles", req_cnt - r0, 32'd4);
        chk("timeout pulse", {31'd0, mem_timeout}, 32'd1);
        chk("timeout wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
`endif

        for (int i = 0; i < 250; i++) begin
            random_instr();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // asynchronous reset in the middle of an access
        chk_en = 1'b0;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
        ex_pc_to_reg = 1'b0; ex_alu_res = 32'h80; ex_write_addr = 5'd2; dmem_ack = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("pre-reset dmem_req", {31'd0, dmem_req}, 32'd1);
        chk("pre-reset stall_out", {31'd0, stall_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("async reset stall_out", {31'd0, stall_out}, 32'd0);
        chk("async reset dmem_addr", {24'd0, dmem_addr}, 32'd0);
        @(negedge clk);
        clear_tl();
        reset = 1'b0;
        chk_en = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined MIPS32 core; sits directly downstream of the ID/EX → EX path.
- Consumes the EX/MEM bundle: ALU result, store data, destination register, control bits.
- Runs loads/stores against the data memory over a req/ack handshake and stalls upstream while an access is outstanding.
- Produces the registered MEM/WB bundle that drives register-file write-back.

Parameters:
- ADDR_W, 8, data-memory address width; dmem_addr = ex_alu_res[ADDR_W-1:0].
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM bundle holds a real instruction.
- ex_alu_res  in  32  ALU result / effective address.
- ex_store_data  in  32  store data (rt value).
- ex_write_addr  in  5  destination register.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_reg_write  in  1  instruction writes the register file.
- ex_pc_to_reg  in  1  write-back selects ex_pc_plus4 (jal).
- ex_pc_plus4  in  32  link address.
- stall_out  out  1  upstream must hold its EX/MEM contents.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  access complete (single-cycle pulse).
- wb_valid  out  1  MEM/WB bundle valid.
- wb_data  out  32  write-back value.
- wb_write_addr  out  5  write-back register.
- wb_reg_write  out  1  register-file write enable.
- mem_misaligned  out  1  one-cycle pulse: word access with addr[1:0] != 0.
- mem_timeout  out  1  one-cycle pulse: access aborted.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs and internal latches = 0, immediately, including mid-access.
- FSM states: IDLE, ACCESS. stall_out = (state == ACCESS), decoded from state only.
- Memory op: ex_mem_read | ex_mem_write.
- IDLE, ex_valid = 0: wb_valid <= 0.
- IDLE, ex_valid = 1, no memory op:
  - Next edge: wb_valid <= 1; wb_data <= ex_pc_to_reg ? ex_pc_plus4 : ex_alu_res.
  - wb_write_addr <= ex_write_addr; wb_reg_write <= ex_reg_write & (ex_write_addr != 0).
  - Latency 1 cycle; remain IDLE.
- IDLE, ex_valid = 1, memory op, ex_alu_res[1:0] != 0:
  - No dmem_req issued.
  - Next edge: wb_valid <= 1, wb_reg_write <= 0, mem_misaligned <= 1 for one cycle; remain IDLE.
- IDLE, ex_valid = 1, memory op, aligned:
  - Latch address, store data, dest register, and control bits.
  - Next edge: dmem_req <= 1, dmem_we <= ex_mem_write, state <= ACCESS, wb_valid <= 0.
  - Both read and write set: write wins; reg write-back suppressed.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata held stable until dmem_ack.
  - On dmem_ack, next edge: dmem_req <= 0, state <= IDLE, wb_valid <= 1, wb_write_addr <= latched dest.
  - Load completion: wb_data <= dmem_rdata; wb_reg_write <= latched reg_write & (dest != 0).
  - Store completion: wb_reg_write <= 0.
- Timing:
  - Accepted at edge N: dmem_req high from N.
  - ack sampled at edge N+k: wb_valid high during cycle N+k to N+k+1.
  - stall_out high from N to N+k; upstream's next instruction is accepted at edge N+k+1 (one bubble).
- dmem_ack while IDLE: ignored. ex_* inputs while ACCESS: ignored (upstream is stalled).
- wb_valid, mem_misaligned, mem_timeout: each high at most one cycle per instruction.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - Reaching TIMEOUT_CYCLES without ack, next edge: dmem_req <= 0, state <= IDLE, wb_valid <= 1, wb_reg_write <= 0, mem_timeout <= 1 for one cycle.
  - ack on the same cycle as the limit: ack wins, normal completion.
- Undefined: no counter; ACCESS waits indefinitely; mem_timeout tied 0.

Test Plan:
- Reset held, then released with ex_valid=0 → all outputs 0, stall_out=0; reset asserted during ACCESS → dmem_req drops the same cycle, state IDLE.
- ALU op ex_alu_res=0x1234, ex_write_addr=5, ex_reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_write_addr=5, wb_reg_write=1, no dmem_req.
- Load addr 0x10, ack after 3 cycles with rdata=0xDEADBEEF → dmem_req high 3 cycles, stall_out high 3 cycles; then wb_data=0xDEADBEEF, wb_reg_write=1; held follow-on instruction completes one cycle later.
- Store addr 0x20, data 0xA5A5A5A5, immediate ack → dmem_we=1, dmem_wdata=0xA5A5A5A5, wb_valid=1, wb_reg_write=0; jal with ex_pc_plus4=0x44, dest 31 → wb_data=0x44; ALU op to dest 0 → wb_reg_write=0.
- Load addr 0x13 → no dmem_req, mem_misaligned pulse, wb_reg_write=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives → dmem_req drops after 4 ACCESS cycles, mem_timeout pulses, wb_reg_write=0.
